// File: rtl/seven_seg_scanner_pkg.sv
// seven_seg_scanner_pkg: glyph/polarity constants and scan phase type shared by the display scanner
package seven_seg_scanner_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       SEG_ON    = 1'b0;
  localparam logic       AN_ON     = 1'b0;
  typedef enum logic {PH_GHOST, PH_DRIVE} phase_e;
endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD -> active-low {g,f,e,d,c,b,a} glyph; codes A..F show a dash
// Ports: i_bcd (4-bit digit), o_seg (7-bit active-low segments)
module bcd_to_seg7
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode 7-seg scanner with anti-ghost blanking and per-frame snapshot
// Ports: i_clk, i_reset (sync, active-high), i_digits (BCD, digit k at [4k+3:4k]), i_dp (dp per digit),
//        o_seg/o_dp/o_an (active-low, registered), o_frame (pulse when the snapshot is taken)
// Build option: define SEVSEG_LZ_BLANK_EN for leading-zero blanking
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int CLK_HZ       = 100000000,
  parameter int SCAN_HZ      = 1000,
  parameter int GHOST_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame
);
  localparam int SLOT = CLK_HZ / SCAN_HZ;
  localparam int CW = $clog2(SLOT);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT - 1);
  localparam logic [CW-1:0] GHOST = CW'(GHOST_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam phase_e PH_RST = GHOST_CYCLES > 0 ? PH_GHOST : PH_DRIVE;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  phase_e ph_q, ph_d;
  logic [4*NUM_DIGITS-1:0] sh_q, sh_d;
  logic [NUM_DIGITS-1:0] shdp_q, shdp_d, blank_q, blank_d, lz;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0] seg_q, glyph;
  logic [3:0] cur;
  logic dp_q, frame_q, snap;
`ifdef SEVSEG_LZ_BLANK_EN
  logic zero_run;
`endif
  bcd_to_seg7 u_glyph (.i_bcd(cur), .o_seg(glyph));
  // Next-state shadow values feed the output mux so the first cycle of a new frame already sees the snapshot.
  always_comb begin
    snap = cnt_q == '0 && idx_q == '0;
    cnt_d = cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
    idx_d = cnt_q != CNT_LAST ? idx_q : idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
    ph_d = cnt_d < GHOST ? PH_GHOST : PH_DRIVE;
    sh_d = snap ? i_digits : sh_q;
    shdp_d = snap ? i_dp : shdp_q;
    lz = '0;
`ifdef SEVSEG_LZ_BLANK_EN
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run & (i_digits[4*k +: 4] == 4'd0);
      lz[k] = zero_run;
    end
`endif
    blank_d = snap ? lz : blank_q;
    cur = sh_d[4*idx_q +: 4];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      ph_q    <= PH_RST;
      sh_q    <= '0;
      shdp_q  <= '0;
      blank_q <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      sh_q    <= sh_d;
      shdp_q  <= shdp_d;
      blank_q <= blank_d;
      an_q    <= ph_q == PH_DRIVE ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      seg_q   <= ph_q == PH_DRIVE && !blank_d[idx_q] ? glyph : SEG_BLANK;
      dp_q    <= ph_q == PH_DRIVE ? ~shdp_d[idx_q] : 1'b1;
      frame_q <= snap;
    end
  end
  assign o_an = an_q;
  assign o_seg = seg_q;
  assign o_dp = dp_q;
  assign o_frame = frame_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: table-driven frame checks plus tear, mid-slot reset and random anode-exclusivity run
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] dig = '0;
  logic [2:0] dp = '0;
  logic [6:0] seg;
  logic sdp, frame;
  logic [2:0] an;
  int n_tests = 0;
  int n_fail = 0;
`ifdef SEVSEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  typedef struct {
    logic [11:0] d;
    logic [2:0]  p;
    logic [20:0] s_off;
    logic [20:0] s_on;
  } vec_t;
  vec_t v[8];

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(3), .CLK_HZ(100), .SCAN_HZ(10), .GHOST_CYCLES(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_digits(dig), .i_dp(dp),
    .o_seg(seg), .o_dp(sdp), .o_an(an), .o_frame(frame)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got an/seg/dp/frame=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_frame(input string nm);
    int k;
    k = 0;
    while (frame !== 1'b1 && k < 40) begin
      step;
      k++;
    end
    if (frame !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no o_frame within 40 cycles, got %b expected 1", nm, frame);
    end
  endtask

  // j counts cycles from the o_frame sample; cycle j shows slot position j%10 of digit j/10.
  task automatic check_frame(input string nm, input logic [20:0] es, input logic [2:0] edp,
                             input int chg_at, input logic [11:0] chg_val);
    int idx;
    logic blank;
    logic [2:0] ean;
    logic [6:0] eseg;
    logic edpo;
    for (int j = 0; j < 30; j++) begin
      if (j > 0) step;
      if (j == chg_at) dig = chg_val;
      idx = j / 10;
      blank = (j % 10) < 2;
      ean = 3'b001 << idx;
      ean = blank ? 3'b111 : ~ean;
      eseg = blank ? 7'h7F : es[7*idx +: 7];
      edpo = blank ? 1'b1 : ~edp[idx];
      chk(nm, {an, seg, sdp, frame}, {ean, eseg, edpo, j == 0});
    end
  endtask

  initial begin
    v[0] = '{12'h123, 3'b000, {7'h79, 7'h24, 7'h30}, {7'h79, 7'h24, 7'h30}};
    v[1] = '{12'h456, 3'b000, {7'h19, 7'h12, 7'h02}, {7'h19, 7'h12, 7'h02}};
    v[2] = '{12'h0AF, 3'b000, {7'h40, 7'h3F, 7'h3F}, {7'h7F, 7'h3F, 7'h3F}};
    v[3] = '{12'h000, 3'b000, {7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h40}};
    v[4] = '{12'h009, 3'b000, {7'h40, 7'h40, 7'h10}, {7'h7F, 7'h7F, 7'h10}};
    v[5] = '{12'h789, 3'b010, {7'h78, 7'h00, 7'h10}, {7'h78, 7'h00, 7'h10}};
    v[6] = '{12'h305, 3'b111, {7'h30, 7'h40, 7'h12}, {7'h30, 7'h40, 7'h12}};
    v[7] = '{12'h0F0, 3'b100, {7'h40, 7'h3F, 7'h40}, {7'h7F, 7'h3F, 7'h40}};
    step;
    step;
    chk("reset", {an, seg, sdp, frame}, {3'b111, 7'h7F, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) begin
      dig = v[i].d;
      dp = v[i].p;
      rst = 1'b0;
      wait_frame($sformatf("vec%0d_frame", i));
      check_frame($sformatf("vec%0d", i), LZ ? v[i].s_on : v[i].s_off, v[i].p, -1, 12'h0);
    end
    dig = 12'h123;
    dp = 3'b000;
    wait_frame("tear_frame");
    check_frame("tear_old", {7'h79, 7'h24, 7'h30}, 3'b000, 15, 12'h456);
    wait_frame("tear_next_frame");
    check_frame("tear_new", {7'h19, 7'h12, 7'h02}, 3'b000, -1, 12'h0);
    for (int k = 0; k < 40 && an === 3'b111; k++) step;
    rst = 1'b1;
    step;
    chk("mid_reset", {an, seg, sdp, frame}, {3'b111, 7'h7F, 1'b1, 1'b0});
    rst = 1'b0;
    wait_frame("post_reset_frame");
    check_frame("post_reset", {7'h19, 7'h12, 7'h02}, 3'b000, -1, 12'h0);
    for (int k = 0; k < 1000; k++) begin
      dig = 12'($urandom);
      dp = 3'($urandom);
      step;
      n_tests++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL onehot_an: got o_an=%b expected at most one zero", an);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
